// File: rtl/spoc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spoc_pkg
//  Description : Shared constants for the SpoC-64 output formatter: opcodes,
//                segment types, status words, header field positions and
//                FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package spoc_pkg;

    // Instruction opcodes (cmd[31:28])
    localparam logic [3:0] c_OP_ENC = 4'h2;
    localparam logic [3:0] c_OP_DEC = 4'h3;

    // Segment types
    localparam logic [3:0] c_SEG_PT  = 4'h4;
    localparam logic [3:0] c_SEG_CT  = 4'h5;
    localparam logic [3:0] c_SEG_TAG = 4'h8;

    // Final status words
    localparam logic [31:0] c_STATUS_SUCCESS = 32'hE000_0000;
    localparam logic [31:0] c_STATUS_FAILURE = 32'hF000_0000;

    // Header field bit positions
    localparam int c_HDR_TYPE_LSB = 28;
    localparam int c_HDR_PARTIAL  = 26;
    localparam int c_HDR_EOI      = 25;
    localparam int c_HDR_EOT      = 24;
    localparam int c_HDR_LEN_W    = 16;

    // Tag segment header without its length: type TAG, EOI=1, EOT=1
    localparam logic [31:0] c_TAG_HDR_BASE = 32'h8300_0000;

    // Tag segment header carrying the tag length in bytes (0x8300_0008 for 2 words)
    function automatic logic [31:0] tag_hdr(input int unsigned words);
        tag_hdr = c_TAG_HDR_BASE | {16'h0000, 16'(words * 4)};
    endfunction

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_ST_IDLE      = 3'd0;
    localparam state_t c_ST_LD_HDR    = 3'd1;
    localparam state_t c_ST_OUT_HDR   = 3'd2;
    localparam state_t c_ST_OUT_DATA  = 3'd3;
    localparam state_t c_ST_OUT_THDR  = 3'd4;
    localparam state_t c_ST_OUT_TAG   = 3'd5;
    localparam state_t c_ST_WAIT_AUTH = 3'd6;
    localparam state_t c_ST_OUT_STAT  = 3'd7;

endpackage : spoc_pkg
`default_nettype wire

// File: rtl/bdo_byte_mask.sv
`default_nettype none
// ============================================================================
//  Module      : bdo_byte_mask
//  Description : Zeroes the invalid trailing bytes of a big-endian bdo word
//                according to its valid-byte count. Out-of-range counts keep
//                the whole word.
//  Revision    : 1.0 - initial release
// ============================================================================
module bdo_byte_mask (
    input  logic [31:0] i_data,
    input  logic [3:0]  i_size,
    output logic [31:0] o_data
);

    logic [31:0] w_mask;

    // Keep the upper i_size bytes; 0 or >4 means a full word
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        case (i_size)
            4'd1:    w_mask = 32'hFF00_0000;
            4'd2:    w_mask = 32'hFFFF_0000;
            4'd3:    w_mask = 32'hFFFF_FF00;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
        o_data = i_data & w_mask;
    end

endmodule : bdo_byte_mask
`default_nettype wire

// File: rtl/bdo_post_processor.sv
`default_nettype none
// ============================================================================
//  Module      : bdo_post_processor
//  Description : SpoC-64 output formatter. Translates the message segment
//                header, forwards masked message words, appends the tag
//                segment (ENC) or consumes the auth result (DEC), and closes
//                each operation with a status word.
//  Revision    : 1.0 - initial release
// ============================================================================
module bdo_post_processor
    import spoc_pkg::*;
#(
    parameter int TAG_WORDS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] bdo,
    input  logic        bdo_valid,
    output logic        bdo_ready,
    input  logic [3:0]  bdo_size,
    input  logic        end_of_block,
    input  logic        msg_auth,
    input  logic        msg_auth_valid,
    output logic        msg_auth_ready,
    output logic [31:0] do_data,
    output logic        do_valid,
    input  logic        do_ready,
    output logic        do_last
);

    localparam int c_TAG_CNT_W = (TAG_WORDS > 1) ? $clog2(TAG_WORDS) : 1;
    localparam logic [31:0] c_TAG_HDR = tag_hdr(TAG_WORDS);

    state_t                   r_state;
    logic                     r_dec;
    logic [14:0]              r_words_left;
    logic [c_TAG_CNT_W-1:0]   r_tag_cnt;
    logic [31:0]              r_word;

    logic [31:0]              w_masked;
    logic [31:0]              w_hdr_xlat;
    logic [3:0]               w_type;
    logic [16:0]              w_len_sum;
    logic [14:0]              w_words_init;
    state_t                   w_tail_state;
    logic                     w_do_xfer;
    logic                     w_unused_ok;

    // end_of_block carries no information this block needs
    assign w_unused_ok = end_of_block;

    bdo_byte_mask u_mask (
        .i_data (bdo),
        .i_size (bdo_size),
        .o_data (w_masked)
    );

    // Word count rounds the byte length up; 17-bit sum so L=65535 cannot overflow
    assign w_len_sum    = {1'b0, cmd[c_HDR_LEN_W-1:0]} + 17'd3;
    assign w_words_init = w_len_sum[16:2];

    // After the last message word: tag segment on ENC, auth wait on DEC
    assign w_tail_state = r_dec ? c_ST_WAIT_AUTH : c_ST_OUT_THDR;

    assign w_do_xfer = do_valid & do_ready;

    // Translate the incoming message header: PT<->CT, EOI=dec, EOT=1
    always_comb begin
        w_type     = cmd[c_HDR_TYPE_LSB +: 4];
        w_hdr_xlat = cmd;
        if (!r_dec && (w_type == c_SEG_PT)) begin
            w_hdr_xlat[c_HDR_TYPE_LSB +: 4] = c_SEG_CT;
        end else if (r_dec && (w_type == c_SEG_CT)) begin
            w_hdr_xlat[c_HDR_TYPE_LSB +: 4] = c_SEG_PT;
        end
        w_hdr_xlat[c_HDR_EOI] = r_dec;
        w_hdr_xlat[c_HDR_EOT] = 1'b1;
    end

    // Handshake and output muxing per state; everything quiet while in reset
    always_comb begin
        cmd_ready      = 1'b0;
        bdo_ready      = 1'b0;
        msg_auth_ready = 1'b0;
        do_valid       = 1'b0;
        do_last        = 1'b0;
        do_data        = 32'h0000_0000;
        if (!rst) begin
            case (r_state)
                c_ST_IDLE, c_ST_LD_HDR: cmd_ready = 1'b1;
                c_ST_OUT_HDR, c_ST_OUT_THDR: begin
                    do_valid = 1'b1;
                    do_data  = r_word;
                end
                c_ST_OUT_DATA: begin
                    do_valid  = bdo_valid;
                    bdo_ready = do_ready;
                    do_data   = w_masked;
                end
                c_ST_OUT_TAG: begin
                    do_valid  = bdo_valid;
                    bdo_ready = do_ready;
                    do_data   = bdo;
                end
                c_ST_WAIT_AUTH: msg_auth_ready = 1'b1;
                c_ST_OUT_STAT: begin
                    do_valid = 1'b1;
                    do_last  = 1'b1;
                    do_data  = r_word;
                end
                default: ;
            endcase
        end
    end

    // Operation sequencer: header, data, tag/auth, status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_dec        <= 1'b0;
            r_words_left <= '0;
            r_tag_cnt    <= '0;
            r_word       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd[c_HDR_TYPE_LSB +: 4] == c_OP_ENC) begin
                            r_dec   <= 1'b0;
                            r_state <= c_ST_LD_HDR;
                        end else if (cmd[c_HDR_TYPE_LSB +: 4] == c_OP_DEC) begin
                            r_dec   <= 1'b1;
                            r_state <= c_ST_LD_HDR;
                        end
                    end
                end
                c_ST_LD_HDR: begin
                    if (cmd_valid) begin
                        r_words_left <= w_words_init;
                        r_word       <= w_hdr_xlat;
                        r_state      <= c_ST_OUT_HDR;
                    end
                end
                c_ST_OUT_HDR: begin
                    if (do_ready) begin
                        if (r_words_left != 15'd0) begin
                            r_state <= c_ST_OUT_DATA;
                        end else begin
                            r_word  <= c_TAG_HDR;
                            r_state <= w_tail_state;
                        end
                    end
                end
                c_ST_OUT_DATA: begin
                    if (w_do_xfer) begin
                        r_words_left <= r_words_left - 15'd1;
                        if (r_words_left == 15'd1) begin
                            r_word  <= c_TAG_HDR;
                            r_state <= w_tail_state;
                        end
                    end
                end
                c_ST_OUT_THDR: begin
                    if (do_ready) begin
                        r_tag_cnt <= '0;
                        r_state   <= c_ST_OUT_TAG;
                    end
                end
                c_ST_OUT_TAG: begin
                    if (w_do_xfer) begin
                        if (r_tag_cnt == c_TAG_CNT_W'(TAG_WORDS - 1)) begin
                            r_word  <= c_STATUS_SUCCESS;
                            r_state <= c_ST_OUT_STAT;
                        end else begin
                            r_tag_cnt <= r_tag_cnt + 1'b1;
                        end
                    end
                end
                c_ST_WAIT_AUTH: begin
                    if (msg_auth_valid) begin
                        r_word  <= msg_auth ? c_STATUS_SUCCESS : c_STATUS_FAILURE;
                        r_state <= c_ST_OUT_STAT;
                    end
                end
                c_ST_OUT_STAT: begin
                    if (do_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule : bdo_post_processor
`default_nettype wire

// File: tb/tb_bdo_post_processor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bdo_post_processor
//  Description : Directed self-checking bench for bdo_post_processor.
//                Inputs change 1 ns after the rising edge; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bdo_post_processor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] bdo;
    logic        bdo_valid;
    logic        bdo_ready;
    logic [3:0]  bdo_size;
    logic        end_of_block;
    logic        msg_auth;
    logic        msg_auth_valid;
    logic        msg_auth_ready;
    logic [31:0] do_data;
    logic        do_valid;
    logic        do_ready;
    logic        do_last;

    int n_checks = 0;
    int n_errors = 0;

    bdo_post_processor #(.TAG_WORDS(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .bdo            (bdo),
        .bdo_valid      (bdo_valid),
        .bdo_ready      (bdo_ready),
        .bdo_size       (bdo_size),
        .end_of_block   (end_of_block),
        .msg_auth       (msg_auth),
        .msg_auth_valid (msg_auth_valid),
        .msg_auth_ready (msg_auth_ready),
        .do_data        (do_data),
        .do_valid       (do_valid),
        .do_ready       (do_ready),
        .do_last        (do_last)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Offer one cmd word and wait (bounded) for acceptance
    task automatic send_cmd(input string tag, input logic [31:0] w);
        int n;
        cmd = w;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd = '0;
    endtask

    // Expect a register-driven word (header/tag header/status), optionally stalled first
    task automatic expect_word(input string tag, input logic [31:0] exp,
                               input logic exp_last, input int stalls);
        int n;
        do_ready = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, 32'(do_valid), 32'd1);
            chk({tag, "_stall_data"}, do_data, exp);
            @(posedge clk); #1;
        end
        do_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!do_valid && n < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, 32'(do_valid), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'd0);
        chk({tag, "_data"}, do_data, exp);
        chk({tag, "_last"}, 32'(do_last), 32'(exp_last));
        @(posedge clk); #1;
        do_ready = 1'b0;
    endtask

    // Pass one bdo word through, optionally with do_ready stalls first
    task automatic xfer_bdo(input string tag, input logic [31:0] w, input logic [3:0] size,
                            input logic [31:0] exp, input int stalls);
        bdo = w;
        bdo_size = size;
        bdo_valid = 1'b1;
        do_ready = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            @(negedge clk);
            chk({tag, "_stall_bdo_ready"}, 32'(bdo_ready), 32'd0);
            chk({tag, "_stall_valid"}, 32'(do_valid), 32'd1);
            @(posedge clk); #1;
        end
        do_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_bdo_ready"}, 32'(bdo_ready), 32'd1);
        chk({tag, "_valid"}, 32'(do_valid), 32'd1);
        chk({tag, "_data"}, do_data, exp);
        chk({tag, "_last"}, 32'(do_last), 32'd0);
        chk({tag, "_auth_ready"}, 32'(msg_auth_ready), 32'd0);
        @(posedge clk); #1;
        bdo_valid = 1'b0;
        do_ready = 1'b0;
        bdo = '0;
    endtask

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd = '0;
        cmd_valid = 1'b0;
        bdo = '0;
        bdo_valid = 1'b0;
        bdo_size = 4'd4;
        end_of_block = 1'b0;
        msg_auth = 1'b0;
        msg_auth_valid = 1'b0;
        do_ready = 1'b0;

        // Reset behaviour
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_do_valid", 32'(do_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bdo_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_do_valid", 32'(do_valid), 32'd0);
        chk("post_rst_bdo_ready_held", 32'(bdo_ready), 32'd0);
        chk("post_rst_auth_ready", 32'(msg_auth_ready), 32'd0);
        chk("post_rst_do_last", 32'(do_last), 32'd0);
        @(posedge clk); #1;
        bdo_valid = 1'b0;

        // ENC, L=6
        send_cmd("enc6_ins", 32'h2000_0000);
        send_cmd("enc6_hdr", 32'h4100_0006);
        expect_word("enc6_hdr", 32'h5100_0006, 1'b0, 0);
        xfer_bdo("enc6_d0", 32'h1122_3344, 4'd4, 32'h1122_3344, 0);
        xfer_bdo("enc6_d1", 32'h5566_7788, 4'd2, 32'h5566_0000, 0);
        expect_word("enc6_thdr", 32'h8300_0008, 1'b0, 0);
        xfer_bdo("enc6_t0", 32'hAAAA_AAAA, 4'd4, 32'hAAAA_AAAA, 0);
        xfer_bdo("enc6_t1", 32'hBBBB_BBBB, 4'd1, 32'hBBBB_BBBB, 0);
        expect_word("enc6_stat", 32'hE000_0000, 1'b1, 0);

        // DEC, L=4, auth ok
        send_cmd("dec4_ins", 32'h3000_0000);
        send_cmd("dec4_hdr", 32'h5000_0004);
        expect_word("dec4_hdr", 32'h4300_0004, 1'b0, 0);
        xfer_bdo("dec4_d0", 32'hDEAD_BEEF, 4'd4, 32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("dec4_wait_auth_ready", 32'(msg_auth_ready), 32'd1);
        chk("dec4_wait_no_thdr", 32'(do_valid), 32'd0);
        msg_auth = 1'b1;
        msg_auth_valid = 1'b1;
        @(posedge clk); #1;
        msg_auth_valid = 1'b0;
        expect_word("dec4_stat", 32'hE000_0000, 1'b1, 0);

        // DEC, L=3, auth fail; auth result already valid on entry to WAIT_AUTH
        send_cmd("dec3_ins", 32'h3000_0000);
        send_cmd("dec3_hdr", 32'h5000_0003);
        msg_auth = 1'b0;
        msg_auth_valid = 1'b1;
        expect_word("dec3_hdr", 32'h4300_0003, 1'b0, 0);
        xfer_bdo("dec3_d0", 32'h0102_0304, 4'd3, 32'h0102_0300, 0);
        @(negedge clk);
        chk("dec3_auth_ready", 32'(msg_auth_ready), 32'd1);
        @(posedge clk); #1;
        msg_auth_valid = 1'b0;
        expect_word("dec3_stat", 32'hF000_0000, 1'b1, 0);

        // ENC, L=0
        send_cmd("enc0_ins", 32'h2000_0000);
        send_cmd("enc0_hdr", 32'h4000_0000);
        expect_word("enc0_hdr", 32'h5100_0000, 1'b0, 0);
        expect_word("enc0_thdr", 32'h8300_0008, 1'b0, 0);
        xfer_bdo("enc0_t0", 32'h0BAD_F00D, 4'd4, 32'h0BAD_F00D, 0);
        xfer_bdo("enc0_t1", 32'hFEED_FACE, 4'd4, 32'hFEED_FACE, 0);
        expect_word("enc0_stat", 32'hE000_0000, 1'b1, 0);

        // Backpressure: ENC, L=8 with do_ready stalls everywhere
        send_cmd("bp_ins", 32'h2000_0000);
        send_cmd("bp_hdr", 32'h4100_0008);
        expect_word("bp_hdr", 32'h5100_0008, 1'b0, int'($urandom_range(1, 3)));
        xfer_bdo("bp_d0", 32'hA1B2_C3D4, 4'd0, 32'hA1B2_C3D4, int'($urandom_range(1, 3)));
        xfer_bdo("bp_d1", 32'hE5F6_0718, 4'd7, 32'hE5F6_0718, int'($urandom_range(1, 3)));
        expect_word("bp_thdr", 32'h8300_0008, 1'b0, int'($urandom_range(1, 3)));
        xfer_bdo("bp_t0", 32'h1357_9BDF, 4'd4, 32'h1357_9BDF, int'($urandom_range(1, 3)));
        xfer_bdo("bp_t1", 32'h2468_ACE0, 4'd4, 32'h2468_ACE0, int'($urandom_range(1, 3)));
        expect_word("bp_stat", 32'hE000_0000, 1'b1, int'($urandom_range(1, 3)));

        // Invalid opcode is dropped; a real ENC must follow from IDLE
        send_cmd("bad_op", 32'h7000_0000);
        @(negedge clk);
        chk("bad_op_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("bad_op_idle_do_valid", 32'(do_valid), 32'd0);
        @(posedge clk); #1;
        send_cmd("enc4_ins", 32'h2000_0000);
        send_cmd("enc4_hdr", 32'h4100_0004);
        expect_word("enc4_hdr", 32'h5100_0004, 1'b0, 0);
        xfer_bdo("enc4_d0", 32'h7777_8888, 4'd4, 32'h7777_8888, 0);
        expect_word("enc4_thdr", 32'h8300_0008, 1'b0, 0);
        xfer_bdo("enc4_t0", 32'h1111_1111, 4'd4, 32'h1111_1111, 0);
        xfer_bdo("enc4_t1", 32'h2222_2222, 4'd4, 32'h2222_2222, 0);
        expect_word("enc4_stat", 32'hE000_0000, 1'b1, 0);

        // Reset in the middle of OUT_DATA
        send_cmd("abort_ins", 32'h2000_0000);
        send_cmd("abort_hdr", 32'h4100_0008);
        expect_word("abort_hdr", 32'h5100_0008, 1'b0, 0);
        xfer_bdo("abort_d0", 32'h9999_9999, 4'd4, 32'h9999_9999, 0);
        bdo = 32'h5A5A_5A5A;
        bdo_valid = 1'b1;
        do_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_do_valid", 32'(do_valid), 32'd0);
        chk("abort_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_idle_do_valid", 32'(do_valid), 32'd0);
        chk("abort_idle_bdo_held", 32'(bdo_ready), 32'd0);
        @(posedge clk); #1;
        bdo_valid = 1'b0;
        do_ready = 1'b0;
        send_cmd("enc5_ins", 32'h2000_0000);
        send_cmd("enc5_hdr", 32'h4100_0005);
        expect_word("enc5_hdr", 32'h5100_0005, 1'b0, 0);
        xfer_bdo("enc5_d0", 32'hCAFE_BABE, 4'd4, 32'hCAFE_BABE, 0);
        xfer_bdo("enc5_d1", 32'h1234_5678, 4'd1, 32'h1200_0000, 0);
        expect_word("enc5_thdr", 32'h8300_0008, 1'b0, 0);
        xfer_bdo("enc5_t0", 32'h3333_3333, 4'd4, 32'h3333_3333, 0);
        xfer_bdo("enc5_t1", 32'h4444_4444, 4'd4, 32'h4444_4444, 0);
        expect_word("enc5_stat", 32'hE000_0000, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bdo_post_processor
`default_nettype wire

// File: doc/bdo_post_processor.md
# bdo_post_processor

Output-side formatter for the SpoC-64 core. It sits between the cipher core's `bdo`/`msg_auth` outputs and the external `do` port. It takes the instruction and message segment header from the header command FIFO and emits a translated output segment header. It then forwards message words with the invalid bytes masked, inserts the tag segment on encryption or consumes the authentication result on decryption, and ends every operation with one status word.

## Interface
- `TAG_WORDS`, 2: number of 32-bit tag words the core emits on `bdo` after the message (SpoC-64: 64-bit tag).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd` in 32: header FIFO word; first the instruction, then the message segment header.
- `cmd_valid` in 1 / `cmd_ready` out 1: valid/ready handshake for `cmd`.
- `bdo` in 32: data from the cipher core, big-endian byte order.
- `bdo_valid` in 1 / `bdo_ready` out 1: handshake for `bdo`.
- `bdo_size` in 4: valid bytes in the current `bdo` word, 1..4.
- `end_of_block` in 1: informational only; ignored.
- `msg_auth` in 1: tag compare result, 1 = match.
- `msg_auth_valid` in 1 / `msg_auth_ready` out 1: handshake for `msg_auth`.
- `do_data` out 32: output word.
- `do_valid` out 1 / `do_ready` in 1: output handshake.
- `do_last` out 1: high with the status word only.

## Operation
- Field meanings for `cmd`:
  - Instruction: opcode in bits [31:28]; 0x2 = ENC, 0x3 = DEC. Any other opcode is consumed and dropped, and the FSM stays in IDLE.
  - Header: type in [31:28], partial in [26], EOI in [25], EOT in [24], byte length L in [15:0].
- FSM states and transitions:
  - IDLE: `cmd_ready`=1. On an accepted valid opcode, latch `dec` and go to LD_HDR.
  - LD_HDR: `cmd_ready`=1. On accept, latch L, set `words_left` = (L+3)>>2 (15-bit), and go to OUT_HDR.
  - OUT_HDR: `do_data` = header with the type translated (ENC: 0x4 PT→0x5 CT; DEC: 0x5→0x4), EOI = `dec`, EOT = 1, and all other bits passed through. On accept, go to OUT_DATA if `words_left`≠0. Otherwise go to OUT_THDR if ENC, or WAIT_AUTH if DEC.
  - OUT_DATA: pass-through, with `do_valid`=`bdo_valid` and `bdo_ready`=`do_ready`. `do_data` = `bdo` with bytes beyond `bdo_size` zeroed (upper bytes kept). A `bdo_size` of 0 or >4 is treated as 4. Each transfer decrements `words_left`; the transfer that takes it to 0 exits as from OUT_HDR.
  - OUT_THDR: `do_data` = 0x8300_0008 (tag type, EOI=1, EOT=1, length 4·TAG_WORDS). On accept, go to OUT_TAG.
  - OUT_TAG: same pass-through as OUT_DATA, with no masking. After TAG_WORDS transfers go to OUT_STAT.
  - WAIT_AUTH: `msg_auth_ready`=1. On `msg_auth_valid`, latch `msg_auth` and go to OUT_STAT.
  - OUT_STAT: `do_data` = 0xE000_0000 (success) or 0xF000_0000 (failure; DEC with `msg_auth`=0). `do_last`=1. On accept, return to IDLE.
- Status: ENC always reports success.
- Handshake signals outside the states listed above are 0.
- `bdo` words arriving while the FSM is not in OUT_DATA or OUT_TAG are held off (`bdo_ready`=0), never dropped.

## Timing
- Reset: FSM→IDLE. `cmd_ready`=0 during the reset cycle and 1 in the first cycle after reset; all other outputs 0.
- `rst` mid-operation abandons the message immediately, with no status word. The next cycle behaves as after power-up.
- Header, tag header and status words are driven from registers.
- A header accepted on `cmd` in cycle n appears on `do` with `do_valid`=1 in cycle n+1.
- Data and tag pass-through has zero latency: `bdo`→`do` within the same cycle. `do_ready`→`bdo_ready` is combinational.
- `do_valid`, once asserted for a header/status word, stays high with stable data until `do_ready`.
- Best case back-to-back throughput is 1 word/cycle; each IDLE→LD_HDR step costs one cycle per `cmd` word.
- L=0: no data words; OUT_HDR goes directly to OUT_THDR or WAIT_AUTH.
- L up to 65535 gives a maximum of 16384 words; the 15-bit counter never wraps.
- `msg_auth_valid` may be high on entry to WAIT_AUTH and is consumed in that cycle.

## Structure
- Shared package `spoc_pkg` holds:
  - opcode constants ENC/DEC;
  - segment type constants PT/CT/TAG;
  - STATUS_SUCCESS / STATUS_FAILURE;
  - the tag header constant;
  - the header field bit positions;
  - the FSM state enumeration.
- One natural sub-module: `bdo_byte_mask`, the combinational zeroing of invalid bytes by `bdo_size`.
- The FSM, counters and header register stay in `bdo_post_processor`.

## Test plan
- ENC, L=6:
  - `cmd` 0x2000_0000 then 0x4100_0006 (only EOT set), `bdo` 0x1122_3344 size 4, then 0x5566_7788 size 2, then tag words 0xAAAA_AAAA, 0xBBBB_BBBB.
  - Required `do`: 0x5100_0006, 0x1122_3344, 0x5566_0000, 0x8300_0008, 0xAAAA_AAAA, 0xBBBB_BBBB, 0xE000_0000 (`do_last`).
- DEC, L=4, `msg_auth`=1:
  - Required `do`: 0x4300_0004, the data word, 0xE000_0000.
  - No tag header; `msg_auth_ready` high only in WAIT_AUTH.
- DEC with `msg_auth`=0 → final word 0xF000_0000.
- ENC, L=0 → 0x5100_0000, 0x8300_0008, two tag words, 0xE000_0000.
- Backpressure: random `do_ready` stalls → `bdo_ready` tracks `do_ready`; no word lost or duplicated; header stable while stalled.
- Robustness, part 1: opcode 0x7 → consumed and dropped, then IDLE.
- Robustness, part 2: `rst` asserted during OUT_DATA → next cycle IDLE, `do_valid`=0; a following ENC message formats correctly.
